// File: rtl/posit_normalize_pipe_pkg.sv
// Shared posit geometry, the decoded-value record and the special encodings.
// Consumed by the normalize/round pipeline and its rounding helper.
package posit_normalize_pipe_pkg;

  localparam int NBITS     = 32;
  localparam int ES        = 2;
  localparam int FBITS     = NBITS - ES - 3;
  localparam int MAX_SCALE = (NBITS - 2) << ES;

  localparam logic [NBITS-1:0] POSIT_MAXPOS = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0] POSIT_MINPOS = {{(NBITS-1){1'b0}}, 1'b1};
  localparam logic [NBITS-1:0] POSIT_INF    = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [NBITS-1:0] POSIT_ZERO   = '0;

  typedef struct packed {
    logic             sgn;
    logic [7:0]       scale;
    logic [FBITS-1:0] fraction;
    logic             zero;
    logic             inf;
  } value;

  function automatic logic [NBITS-1:0] posit_negate(input logic [NBITS-1:0] w);
    return ~w + POSIT_MINPOS;
  endfunction

endpackage

// File: rtl/posit_normalize_pipe_round_rne.sv
// Round-to-nearest-even of a posit body, then sign application; purely combinational.
module posit_round_rne
  import posit_normalize_pipe_pkg::*;
(
  input  logic [NBITS-2:0] body,
  input  logic             guard,
  input  logic             sticky,
  input  logic             sgn,
  output logic [NBITS-1:0] word
);

  localparam logic [NBITS-2:0] BODY_ONE = {{(NBITS-2){1'b0}}, 1'b1};

  logic             rnd_up;
  logic [NBITS-2:0] body_r;
  logic [NBITS-1:0] mag;

  always_comb begin
    rnd_up = guard & (body[0] | sticky);
    body_r = body;
    // An all-ones body is already maxpos; incrementing would spill into the sign bit.
    if (rnd_up && (body != '1)) begin
      body_r = body + BODY_ONE;
    end
    if (body_r == '0) begin
      body_r = BODY_ONE;
    end
    mag  = {1'b0, body_r};
    word = sgn ? posit_negate(mag) : mag;
  end

endmodule

// File: rtl/posit_normalize_pipe.sv
// Packs a decoded posit value into an NBITS word with RNE rounding; 3 register stages.
// Latency 3 cycles, 1 word/cycle; bubble-collapsing valid/ready, output held while stalled.
module posit_normalize_pipe
  import posit_normalize_pipe_pkg::*;
(
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  value             in_val,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_posit
);

  localparam int VW   = 2 * NBITS;
  localparam int PADW = VW - 1 - ES - FBITS;

  logic ld1, ld2, ld3;

  logic             s1_v_q, s1_v_d;
  logic             s1_sgn_q, s1_sgn_d;
  logic             s1_zero_q, s1_zero_d;
  logic             s1_inf_q, s1_inf_d;
  logic             s1_sat_hi_q, s1_sat_hi_d;
  logic             s1_sat_lo_q, s1_sat_lo_d;
  logic [5:0]       s1_rl_q, s1_rl_d;
  logic             s1_rpos_q, s1_rpos_d;
  logic [ES-1:0]    s1_e_q, s1_e_d;
  logic [FBITS-1:0] s1_frac_q, s1_frac_d;

  logic             s2_v_q, s2_v_d;
  logic             s2_sgn_q, s2_sgn_d;
  logic             s2_zero_q, s2_zero_d;
  logic             s2_inf_q, s2_inf_d;
  logic             s2_sat_hi_q, s2_sat_hi_d;
  logic             s2_sat_lo_q, s2_sat_lo_d;
  logic [NBITS-2:0] s2_body_q, s2_body_d;
  logic             s2_guard_q, s2_guard_d;
  logic             s2_sticky_q, s2_sticky_d;

  logic             out_valid_q, out_valid_d;
  logic [NBITS-1:0] out_posit_q, out_posit_d;

  logic [9:0]       scale_x;
  logic [5:0]       k;
  logic [5:0]       rl;
  logic [5:0]       sh;
  logic [VW-1:0]    tail, fill, vec;
  logic [NBITS-1:0] rnd_word;
  logic [NBITS-1:0] word_sel;

  // A stage may load whenever it is empty or the stage after it is loading.
  always_comb begin
    ld3 = ~out_valid_q | out_ready;
    ld2 = ~s2_v_q | ld3;
    ld1 = ~s1_v_q | ld2;
  end

  always_comb begin
    scale_x = {{2{in_val.scale[7]}}, in_val.scale};
    k       = scale_x[ES+5:ES];
    rl      = k[5] ? (6'd1 - k) : (k + 6'd2);

    s1_v_d      = s1_v_q;
    s1_sgn_d    = s1_sgn_q;
    s1_zero_d   = s1_zero_q;
    s1_inf_d    = s1_inf_q;
    s1_sat_hi_d = s1_sat_hi_q;
    s1_sat_lo_d = s1_sat_lo_q;
    s1_rl_d     = s1_rl_q;
    s1_rpos_d   = s1_rpos_q;
    s1_e_d      = s1_e_q;
    s1_frac_d   = s1_frac_q;
    if (ld1) begin
      s1_v_d = in_valid;
      if (in_valid) begin
        s1_sgn_d    = in_val.sgn;
        s1_zero_d   = in_val.zero;
        s1_inf_d    = in_val.inf;
        s1_sat_hi_d = ~scale_x[9] & (scale_x > 10'(MAX_SCALE));
        s1_sat_lo_d = scale_x[9] & (scale_x < 10'(-MAX_SCALE));
        s1_rl_d     = rl;
        s1_rpos_d   = ~k[5];
        s1_e_d      = in_val.scale[ES-1:0];
        s1_frac_d   = in_val.fraction;
      end
    end
  end

  // Body is built MSB-aligned in vec: regime run, terminator, exponent, fraction.
  // The run is produced by shifting the terminator down and back-filling with the run bit.
  always_comb begin
    sh   = s1_rl_q - 6'd1;
    tail = {~s1_rpos_q, s1_e_q, s1_frac_q, {PADW{1'b0}}};
    fill = s1_rpos_q ? ~({VW{1'b1}} >> sh) : '0;
    vec  = (tail >> sh) | fill;

    s2_v_d      = s2_v_q;
    s2_sgn_d    = s2_sgn_q;
    s2_zero_d   = s2_zero_q;
    s2_inf_d    = s2_inf_q;
    s2_sat_hi_d = s2_sat_hi_q;
    s2_sat_lo_d = s2_sat_lo_q;
    s2_body_d   = s2_body_q;
    s2_guard_d  = s2_guard_q;
    s2_sticky_d = s2_sticky_q;
    if (ld2) begin
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_sgn_d    = s1_sgn_q;
        s2_zero_d   = s1_zero_q;
        s2_inf_d    = s1_inf_q;
        s2_sat_hi_d = s1_sat_hi_q;
        s2_sat_lo_d = s1_sat_lo_q;
        s2_body_d   = vec[VW-1 -: NBITS-1];
        s2_guard_d  = vec[VW-NBITS];
        s2_sticky_d = |vec[VW-NBITS-1:0];
      end
    end
  end

  posit_round_rne u_round (
    .body   (s2_body_q),
    .guard  (s2_guard_q),
    .sticky (s2_sticky_q),
    .sgn    (s2_sgn_q),
    .word   (rnd_word)
  );

  always_comb begin
    if (s2_inf_q) begin
      word_sel = POSIT_INF;
    end else if (s2_zero_q) begin
      word_sel = POSIT_ZERO;
    end else if (s2_sat_hi_q) begin
      word_sel = s2_sgn_q ? posit_negate(POSIT_MAXPOS) : POSIT_MAXPOS;
    end else if (s2_sat_lo_q) begin
      word_sel = s2_sgn_q ? posit_negate(POSIT_MINPOS) : POSIT_MINPOS;
    end else begin
      word_sel = rnd_word;
    end

    out_valid_d = out_valid_q;
    out_posit_d = out_posit_q;
    if (ld3) begin
      out_valid_d = s2_v_q;
      if (s2_v_q) begin
        out_posit_d = word_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_v_q      <= 1'b0;
      s1_sgn_q    <= 1'b0;
      s1_zero_q   <= 1'b0;
      s1_inf_q    <= 1'b0;
      s1_sat_hi_q <= 1'b0;
      s1_sat_lo_q <= 1'b0;
      s1_rl_q     <= 6'd2;
      s1_rpos_q   <= 1'b0;
      s1_e_q      <= '0;
      s1_frac_q   <= '0;
      s2_v_q      <= 1'b0;
      s2_sgn_q    <= 1'b0;
      s2_zero_q   <= 1'b0;
      s2_inf_q    <= 1'b0;
      s2_sat_hi_q <= 1'b0;
      s2_sat_lo_q <= 1'b0;
      s2_body_q   <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_posit_q <= '0;
    end else begin
      s1_v_q      <= s1_v_d;
      s1_sgn_q    <= s1_sgn_d;
      s1_zero_q   <= s1_zero_d;
      s1_inf_q    <= s1_inf_d;
      s1_sat_hi_q <= s1_sat_hi_d;
      s1_sat_lo_q <= s1_sat_lo_d;
      s1_rl_q     <= s1_rl_d;
      s1_rpos_q   <= s1_rpos_d;
      s1_e_q      <= s1_e_d;
      s1_frac_q   <= s1_frac_d;
      s2_v_q      <= s2_v_d;
      s2_sgn_q    <= s2_sgn_d;
      s2_zero_q   <= s2_zero_d;
      s2_inf_q    <= s2_inf_d;
      s2_sat_hi_q <= s2_sat_hi_d;
      s2_sat_lo_q <= s2_sat_lo_d;
      s2_body_q   <= s2_body_d;
      s2_guard_q  <= s2_guard_d;
      s2_sticky_q <= s2_sticky_d;
      out_valid_q <= out_valid_d;
      out_posit_q <= out_posit_d;
    end
  end

  assign in_ready  = ld1;
  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;

endmodule

// File: tb/tb_posit_normalize_pipe.sv
// Self-checking bench for posit_normalize_pipe: directed encodings plus a queued scoreboard.
module tb_posit_normalize_pipe;
  import posit_normalize_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  value        in_val = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_posit;

  int          n_run = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  bit          mon_en = 1'b0;

  posit_normalize_pipe dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_posit (out_posit)
  );

  always #5 clk = ~clk;

  function automatic value mk(input logic sg, input logic [7:0] sc, input logic [26:0] fr,
                              input logic z, input logic inf);
    value v;
    v.sgn = sg; v.scale = sc; v.fraction = fr; v.zero = z; v.inf = inf;
    return v;
  endfunction

  // Reference: emit the posit bit stream one bit at a time, then round with integers.
  function automatic logic [31:0] model(input value v);
    int sc, k, e, n;
    logic s [0:127];
    logic [30:0] body;
    logic guard, sticky;
    longint mag;
    logic [31:0] r;
    sc = int'($signed(v.scale));
    if (v.inf) return 32'h8000_0000;
    if (v.zero) return 32'h0000_0000;
    if (sc > 120) return v.sgn ? 32'h8000_0001 : 32'h7FFF_FFFF;
    if (sc < -120) return v.sgn ? 32'hFFFF_FFFF : 32'h0000_0001;
    for (int i = 0; i < 128; i++) s[i] = 1'b0;
    n = 0;
    k = (sc >= 0) ? sc / 4 : -((-sc + 3) / 4);
    e = sc - 4 * k;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) begin s[n] = 1'b1; n++; end
      s[n] = 1'b0; n++;
    end else begin
      for (int i = 0; i < -k; i++) begin s[n] = 1'b0; n++; end
      s[n] = 1'b1; n++;
    end
    s[n] = 1'((e >> 1) & 1); n++;
    s[n] = 1'(e & 1); n++;
    for (int i = 26; i >= 0; i--) begin s[n] = v.fraction[i]; n++; end
    body = '0;
    for (int i = 0; i < 31; i++) body = {body[29:0], s[i]};
    guard = s[31];
    sticky = 1'b0;
    for (int i = 32; i < 128; i++) sticky = sticky | s[i];
    mag = longint'(body);
    if (guard && (body[0] || sticky) && body != 31'h7FFF_FFFF) mag++;
    if (mag == 0) mag = 1;
    r = 32'(mag);
    if (v.sgn) r = -r;
    return r;
  endfunction

  function automatic value rand_val();
    value v;
    v.sgn      = 1'($urandom_range(0, 1));
    v.scale    = 8'($urandom_range(0, 255));
    v.fraction = 27'($urandom);
    v.zero     = ($urandom_range(0, 15) == 0);
    v.inf      = ($urandom_range(0, 15) == 0);
    return v;
  endfunction

  // Handshakes are stable at the falling edge; that is where transfers are recorded.
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (in_valid && in_ready) exp_q.push_back(model(in_val));
      if (out_valid && out_ready) got_q.push_back(out_posit);
    end
  end

  task automatic send_one(input value v, output logic [31:0] got, output int lat);
    @(posedge clk); #1;
    in_val = v; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    got = out_posit;
    if (!out_valid) lat = -1;
  endtask

  task automatic drain(input int expect_n);
    for (int c = 0; c < 200 && got_q.size() < exp_q.size(); c++) @(posedge clk);
    repeat (6) @(posedge clk);
    #1;
    mon_en = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_run++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_run++;
    if (out_posit !== 32'h0) begin n_fail++; $display("FAIL reset_out_posit: got %h expected 00000000", out_posit); end
    #10 reset_n = 1'b1;
    #1;
    n_run++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_basic();
    value cv[4];
    logic [31:0] ev[4];
    logic [31:0] got;
    int lat;
    cv[0] = mk(0, 8'd0, 27'h0, 0, 0);   ev[0] = 32'h4000_0000;
    cv[1] = mk(1, 8'd0, 27'h0, 0, 0);   ev[1] = 32'hC000_0000;
    cv[2] = mk(0, 8'd4, 27'h0, 0, 0);   ev[2] = 32'h6000_0000;
    cv[3] = mk(0, 8'hFF, 27'h0, 0, 0);  ev[3] = 32'h3800_0000;
    for (int i = 0; i < 4; i++) begin
      send_one(cv[i], got, lat);
      n_run++;
      if (lat !== 3) begin n_fail++; $display("FAIL basic_latency[%0d]: got %0d expected 3", i, lat); end
      n_run++;
      if (got !== ev[i]) begin n_fail++; $display("FAIL basic_value[%0d]: got %h expected %h", i, got, ev[i]); end
    end
  endtask

  task automatic test_rounding();
    logic [26:0] fr[3];
    logic [31:0] ev[3];
    logic [31:0] got;
    int lat;
    fr[0] = 27'h3; ev[0] = 32'h7000_0001;
    fr[1] = 27'h2; ev[1] = 32'h7000_0000;
    fr[2] = 27'h6; ev[2] = 32'h7000_0002;
    for (int i = 0; i < 3; i++) begin
      send_one(mk(0, 8'd8, fr[i], 0, 0), got, lat);
      n_run++;
      if (got !== ev[i]) begin n_fail++; $display("FAIL rne[%0d]: got %h expected %h", i, got, ev[i]); end
    end
  endtask

  task automatic test_specials();
    value cv[8];
    logic [31:0] ev[8];
    logic [31:0] got;
    int lat;
    cv[0] = mk(0, 8'd5, 27'h123, 1, 0);   ev[0] = 32'h0000_0000;
    cv[1] = mk(1, 8'd5, 27'h123, 0, 1);   ev[1] = 32'h8000_0000;
    cv[2] = mk(0, 8'd5, 27'h123, 1, 1);   ev[2] = 32'h8000_0000;
    cv[3] = mk(0, 8'd127, 27'h0, 0, 0);   ev[3] = 32'h7FFF_FFFF;
    cv[4] = mk(1, 8'h80, 27'h0, 0, 0);    ev[4] = 32'hFFFF_FFFF;
    cv[5] = mk(1, 8'd121, 27'h0, 0, 0);   ev[5] = 32'h8000_0001;
    cv[6] = mk(0, 8'h88, 27'h0, 0, 0);    ev[6] = 32'h0000_0001;
    cv[7] = mk(0, 8'h8B, 27'h0, 0, 0);    ev[7] = 32'h0000_0002;
    for (int i = 0; i < 8; i++) begin
      send_one(cv[i], got, lat);
      n_run++;
      if (got !== ev[i]) begin n_fail++; $display("FAIL special[%0d]: got %h expected %h", i, got, ev[i]); end
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int cyc = 0;
    bit take;
    bit have_held = 1'b0;
    logic [31:0] held = '0;
    exp_q.delete(); got_q.delete();
    @(posedge clk); #1;
    mon_en = 1'b1;
    out_ready = 1'b0;
    in_val = mk(0, 8'hEC, 27'h0, 0, 0);
    in_valid = 1'b1;
    while (cyc < 60 && acc < 6) begin
      @(negedge clk);
      if (!out_ready && acc == 3) begin
        n_run++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      end
      if (!out_ready && out_valid) begin
        if (have_held) begin
          n_run++;
          if (out_posit !== held) begin n_fail++; $display("FAIL bp_stable: got %h expected %h", out_posit, held); end
        end else begin
          held = out_posit;
          have_held = 1'b1;
        end
      end
      take = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (take) begin
        acc++;
        if (acc < 6) in_val = mk(1'(acc), 8'(acc * 9 - 20), 27'(acc * 32'h0123457), 0, 0);
        else in_valid = 1'b0;
      end
      out_ready = (cyc >= 5);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(6);
    n_run++;
    if (!have_held) begin n_fail++; $display("FAIL bp_out_valid_in_stall: got 0 expected 1"); end
    n_run++;
    if (got_q.size() != 6 || exp_q.size() != 6) begin
      n_fail++; $display("FAIL bp_count: got %0d/%0d words expected 6/6", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_run++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_bubbles();
    bit ev;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    mon_en = 1'b1;
    for (int cyc = 0; cyc < 13; cyc++) begin
      @(posedge clk); #1;
      in_valid = (cyc < 8) && (cyc % 2 == 0);
      in_val = mk(1'(cyc / 2), 8'(cyc * 7 - 20), 27'(cyc * 32'h0345_6789), 0, 0);
      @(negedge clk);
      ev = (cyc >= 3) && (cyc <= 9) && ((cyc - 3) % 2 == 0);
      n_run++;
      if (out_valid !== ev) begin n_fail++; $display("FAIL bubble_valid[%0d]: got %b expected %b", cyc, out_valid, ev); end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain(4);
    n_run++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      n_fail++; $display("FAIL bubble_count: got %0d/%0d words expected 4/4", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_run++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bubble_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random(input int nwords);
    int sent = 0;
    int cyc = 0;
    bit take;
    exp_q.delete(); got_q.delete();
    @(posedge clk); #1;
    mon_en = 1'b1;
    in_val = rand_val();
    in_valid = ($urandom_range(0, 9) < 7);
    out_ready = ($urandom_range(0, 9) < 7);
    while (sent < nwords && cyc < 60000) begin
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (take) begin
        sent++;
        in_val = rand_val();
      end
      in_valid = (sent < nwords) && ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain(nwords);
    n_run++;
    if (got_q.size() != nwords || exp_q.size() != nwords) begin
      n_fail++; $display("FAIL random_count: got %0d/%0d words expected %0d", got_q.size(), exp_q.size(), nwords);
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      n_run++;
      if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL random_word[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] got;
    int lat;
    mon_en = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_val = mk(0, 8'(i * 4), 27'h0, 0, 0);
      in_valid = 1'b1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_run++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_full_before: got %b expected 1", out_valid); end
    reset_n = 1'b0;
    #1;
    n_run++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_async_valid: got %b expected 0", out_valid); end
    n_run++;
    if (out_posit !== 32'h0) begin n_fail++; $display("FAIL rst_async_posit: got %h expected 00000000", out_posit); end
    repeat (2) @(posedge clk);
    #2;
    reset_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_run++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_after_release: got %b expected 0", out_valid); end
    send_one(mk(1, 8'd4, 27'h0, 0, 0), got, lat);
    n_run++;
    if (lat !== 3) begin n_fail++; $display("FAIL rst_first_latency: got %0d expected 3", lat); end
    n_run++;
    if (got !== 32'hA000_0000) begin n_fail++; $display("FAIL rst_first_word: got %h expected a0000000", got); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_rounding();
    test_specials();
    test_backpressure();
    test_bubbles();
    test_random(10000);
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
